// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - 512 x 32 wait-stated memory with request/ready handshake
//
// Ports:
//   clock      rising-edge clock
//   clear      asynchronous active-low reset
//   Mem_read   read request (level)
//   Mem_write  write request (level, wins over Mem_read)
//   address    word address, latched at accept
//   data_in    write data, latched at accept
//   data_out   last completed read value
//   Mem_ready  one-cycle completion pulse (DONE state)
//   busy       high in WAIT, ACCESS and DONE
//   wr_fault   one-cycle pulse with Mem_ready when a write was blocked
//
// Optional feature: define MEM_WPROT_EN to block writes below PROT_LIMIT.
module mem_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2,
  parameter int PROT_LIMIT  = 128
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  Mem_read,
  input  logic                  Mem_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  Mem_ready,
  output logic                  busy,
  output logic                  wr_fault
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [31:0] PROT_LIM_U = PROT_LIMIT;

`ifdef MEM_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic                    lat_wr;
  logic [3:0]              wait_cnt;
  logic                    req;
  logic                    accept;
  logic                    wr_blocked;

  assign req    = Mem_read | Mem_write;
  assign accept = (state == S_IDLE) && req;

  // Decided from the latched operands so it stays valid through DONE.
  assign wr_blocked = WPROT_ON && lat_wr && (32'(lat_addr) < PROT_LIM_U);

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: state_nxt = S_DONE;
      // A request still held after completion must drop before re-accept.
      S_DONE:    state_nxt = req ? S_RELEASE : S_IDLE;
      S_RELEASE: state_nxt = req ? S_RELEASE : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Mem_ready = 1'b0;
    busy      = 1'b0;
    wr_fault  = 1'b0;
    case (state)
      S_WAIT, S_ACCESS: busy = 1'b1;
      S_DONE: begin
        busy      = 1'b1;
        Mem_ready = 1'b1;
        wr_fault  = wr_blocked;
      end
      default: ;
    endcase
  end

  // Operand latches, wait counter and read-data register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
      wait_cnt <= 4'd0;
      data_out <= '0;
    end else begin
      if (accept) begin
        lat_addr <= address;
        lat_data <= data_in;
        lat_wr   <= Mem_write;
        wait_cnt <= 4'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == S_ACCESS && !lat_wr) begin
        data_out <= mem[lat_addr];
      end
    end
  end

  // Array has no reset; only the ACCESS exit edge writes it.
  always_ff @(posedge clock) begin
    if (state == S_ACCESS && lat_wr && !wr_blocked) begin
      mem[lat_addr] <= lat_data;
    end
  end

endmodule
